ifetch_stage: RTL

- Instruction-fetch stage directly upstream of ID.
- Holds the PC and issues one-outstanding-request fetches to the instruction cache over a req/ack handshake.
- Presents the instruction, its PC and PC+4 to ID.
- Honours ID's branch/jump redirect, freeze request and the global pipeline stall.

---
 rtl/ifetch_stage_pkg.sv | 24 ++
 rtl/ifetch_hold_buf.sv | 35 +++
 rtl/ifetch_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ifetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default reset PC / bubble word, and small PC arithmetic helpers.
package ifetch_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // Sequential PC, wraps modulo 2^32
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Redirect targets are forced onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/ifetch_hold_buf.sv
// One-entry parking buffer for a fetched instruction and its PC while the
// pipeline is stalled or ID has asked for a freeze.
module ifetch_hold_buf
  import ifetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Load has priority over drain; flush and reset empty the entry
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: holds the PC, issues single-outstanding fetches
// to the I-cache and presents instruction / PC / PC+4 to ID.
// Optional macro IFETCH_PERF_EN adds saturating Fetch_Count / Squash_Count.
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall,
  input  logic [31:0] Alt_PC,
  input  logic        Request_Alt_PC,
  input  logic        WANT_FREEZE,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Data,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] Fetch_Count,
  output logic [31:0] Squash_Count
`endif
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  addr_q;
  logic         squash, squash_next;

  logic         redirect, blocked;
  logic [31:0]  alt_target;
  logic         deliver;
  logic [31:0]  dl_instr, dl_pc;
  logic         buf_load, buf_drain, buf_flush;
  logic         buf_valid;
  logic [31:0]  buf_instr, buf_pc;

  assign redirect   = Request_Alt_PC && !stall;
  assign blocked    = stall || WANT_FREEZE;
  assign alt_target = word_align(Alt_PC);

  // The issued address is latched so a redirect during S_WAIT can move the
  // PC without disturbing the address the cache is still servicing.
  assign IMem_Req  = !RESET && (state != S_HOLD);
  assign IMem_Addr = (state == S_WAIT) ? addr_q : pc;

  ifetch_hold_buf u_hold_buf (
    .clk        (CLK),
    .reset      (RESET),
    .load       (buf_load),
    .drain      (buf_drain),
    .flush      (buf_flush),
    .load_instr (IMem_Data),
    .load_pc    (pc),
    .valid      (buf_valid),
    .instr      (buf_instr),
    .pc         (buf_pc)
  );

  // Next-state, PC and delivery decisions
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    squash_next = squash;
    buf_load    = 1'b0;
    buf_drain   = 1'b0;
    buf_flush   = 1'b0;
    deliver     = 1'b0;
    dl_instr    = buf_instr;
    dl_pc       = buf_pc;
    case (state)
      S_REQ, S_WAIT: begin
        if (IMem_Ack) begin
          if (squash || redirect) begin
            // Wrong-path response: discard and refetch from the current PC
            squash_next = 1'b0;
            state_next  = S_REQ;
            if (redirect) pc_next = alt_target;
          end else if (blocked) begin
            buf_load   = 1'b1;
            state_next = S_HOLD;
          end else begin
            deliver  = 1'b1;
            dl_instr = IMem_Data;
            dl_pc    = pc;
          end
        end else begin
          state_next = S_WAIT;
          if (redirect) begin
            pc_next     = alt_target;
            squash_next = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          buf_flush  = 1'b1;
          state_next = S_REQ;
          pc_next    = alt_target;
        end else if (!blocked && buf_valid) begin
          buf_drain = 1'b1;
          deliver   = 1'b1;
        end
      end
      default: state_next = S_REQ;
    endcase
    if (deliver) begin
      pc_next    = pc_plus4(dl_pc);
      state_next = S_REQ;
    end
  end

  // FSM, PC and squash registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      squash <= 1'b0;
      addr_q <= RESET_PC;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      squash <= squash_next;
      if (state == S_REQ) addr_q <= pc;
    end
  end

  // ID-facing outputs: deliver, bubble, or hold under stall
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Instr1_OUT         <= NOP_INSTR;
      Instr_PC_OUT       <= '0;
      Instr_PC_Plus4_OUT <= 32'd4;
    end else if (deliver) begin
      Instr1_OUT         <= dl_instr;
      Instr_PC_OUT       <= dl_pc;
      Instr_PC_Plus4_OUT <= pc_plus4(dl_pc);
    end else if (!stall) begin
      Instr1_OUT         <= NOP_INSTR;
      Instr_PC_OUT       <= pc_next;
      Instr_PC_Plus4_OUT <= pc_plus4(pc_next);
    end
  end

`ifdef IFETCH_PERF_EN
  logic dropped;
  assign dropped = (state == S_HOLD) ? redirect
                                     : (IMem_Ack && (squash || redirect));

  // Saturating performance counters
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Fetch_Count  <= '0;
      Squash_Count <= '0;
    end else begin
      if (deliver && (Fetch_Count != '1))  Fetch_Count  <= Fetch_Count + 32'd1;
      if (dropped && (Squash_Count != '1)) Squash_Count <= Squash_Count + 32'd1;
    end
  end
`endif

endmodule
